// File: rtl/trackball_counter.sv
// ---------------------------------------------------------------------------
// trackball_counter
//
// Turns the trackball emulator's toggle-per-step outputs (h_clk/h_dir,
// v_clk/v_dir) into two wrapping up/down position counters. The game CPU
// reads the counters through a registered read port. Each axis also drives
// 2-bit Gray-code quadrature phases for cores that decode quadrature.
//
// Parameters:
//   COUNT_W       width of each axis counter and of dout
//   CLEAR_ON_READ 1 = the axis being read is zeroed as it is sampled
//   SNAPSHOT      1 = an X read latches Y into a shadow; a Y read returns it
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   h_clk, h_dir     horizontal step toggle / direction (0 = up), async
//   v_clk, v_dir     vertical step toggle / direction (0 = up), async
//   flip             inverts the direction of both axes
//   rd, rd_axis      one-cycle read strobe, axis select (0 = X, 1 = Y)
//   dout, dout_valid registered read data and its one-cycle valid pulse
//   quad_x, quad_y   quadrature phases {B,A} per axis
// ---------------------------------------------------------------------------
module trackball_counter #(
  parameter int COUNT_W       = 8,
  parameter int CLEAR_ON_READ = 0,
  parameter int SNAPSHOT      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               h_clk,
  input  logic               h_dir,
  input  logic               v_clk,
  input  logic               v_dir,
  input  logic               flip,
  input  logic               rd,
  input  logic               rd_axis,
  output logic [COUNT_W-1:0] dout,
  output logic               dout_valid,
  output logic [1:0]         quad_x,
  output logic [1:0]         quad_y
);

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  // Bits [1:0] are the 2-FF synchroniser, bit [2] is the delayed copy used
  // for edge detection.
  logic [2:0] h_clk_sync;
  logic [2:0] v_clk_sync;
  logic [1:0] h_dir_sync;
  logic [1:0] v_dir_sync;

  // After reset releases, the synchroniser pipeline refills from 0 to the
  // current input level. That fill would look like a toggle if h_clk/v_clk
  // sit high, so steps are ignored until the pipeline has settled.
  logic [1:0] arm_cnt;
  logic       armed;

  logic step_h;
  logic step_v;
  logic dir_h;
  logic dir_v;

  logic [COUNT_W-1:0] x_cnt;
  logic [COUNT_W-1:0] y_cnt;
  logic [COUNT_W-1:0] shadow;
  logic [COUNT_W-1:0] x_base;
  logic [COUNT_W-1:0] y_base;
  logic [COUNT_W-1:0] x_next;
  logic [COUNT_W-1:0] y_next;
  logic [COUNT_W-1:0] rd_data;
  logic [1:0]         phase_x;
  logic [1:0]         phase_y;
  logic               rd_x;
  logic               rd_y;

  assign armed = (arm_cnt == 2'd3);

  // Synchronisers, arm counter, and the registered step/direction stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_clk_sync <= '0;
      v_clk_sync <= '0;
      h_dir_sync <= '0;
      v_dir_sync <= '0;
      arm_cnt    <= '0;
      step_h     <= 1'b0;
      step_v     <= 1'b0;
      dir_h      <= 1'b0;
      dir_v      <= 1'b0;
    end else begin
      h_clk_sync <= {h_clk_sync[1:0], h_clk};
      v_clk_sync <= {v_clk_sync[1:0], v_clk};
      h_dir_sync <= {h_dir_sync[0], h_dir};
      v_dir_sync <= {v_dir_sync[0], v_dir};
      if (!armed) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
      // Both edges of the toggle count as one step each.
      step_h <= armed & (h_clk_sync[1] ^ h_clk_sync[2]);
      step_v <= armed & (v_clk_sync[1] ^ v_clk_sync[2]);
      dir_h  <= h_dir_sync[1] ^ flip;
      dir_v  <= v_dir_sync[1] ^ flip;
    end
  end

  // Next counter values: the read clear happens first, then any step in the
  // same cycle is applied on top so it is never lost. With SNAPSHOT the X
  // read is the sampling point for Y as well, so it is the X read that
  // clears live Y and a later Y read (of the shadow) leaves live Y alone.
  always_comb begin
    rd_x    = rd & ~rd_axis;
    rd_y    = rd & rd_axis;
    x_base  = x_cnt;
    y_base  = y_cnt;
    rd_data = x_cnt;
    if (CLEAR_ON_READ != 0) begin
      if (rd_x) begin
        x_base = '0;
      end
      if ((SNAPSHOT != 0) ? rd_x : rd_y) begin
        y_base = '0;
      end
    end
    x_next = x_base;
    if (step_h) begin
      x_next = dir_h ? (x_base - ONE) : (x_base + ONE);
    end
    y_next = y_base;
    if (step_v) begin
      y_next = dir_v ? (y_base - ONE) : (y_base + ONE);
    end
    if (rd_axis) begin
      rd_data = (SNAPSHOT != 0) ? shadow : y_cnt;
    end
  end

  // Counters, shadow and read port. dout holds until the next strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      x_cnt      <= x_next;
      y_cnt      <= y_next;
      dout_valid <= rd;
      if (rd) begin
        dout <= rd_data;
      end
      if ((SNAPSHOT != 0) && rd_x) begin
        shadow <= y_cnt;
      end
    end
  end

  // Quadrature phase counters; untouched by reads and clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_x <= '0;
      phase_y <= '0;
    end else begin
      if (step_h) begin
        phase_x <= dir_h ? (phase_x - 2'd1) : (phase_x + 2'd1);
      end
      if (step_v) begin
        phase_y <= dir_v ? (phase_y - 2'd1) : (phase_y + 2'd1);
      end
    end
  end

  // Binary phase to Gray: 0,1,2,3 -> 00,01,11,10.
  assign quad_x = {phase_x[1], phase_x[1] ^ phase_x[0]};
  assign quad_y = {phase_y[1], phase_y[1] ^ phase_y[0]};

endmodule

// File: tb/tb_trackball_counter.sv
// ---------------------------------------------------------------------------
// tb_trackball_counter
//
// Two instances: dut (CLEAR_ON_READ = 0, SNAPSHOT = 1) and dut_c
// (CLEAR_ON_READ = 1, SNAPSHOT = 1), each with its own step/read inputs.
// Stimulus pushes hand-computed expected read data and quadrature states
// into queues; independent monitors pop and compare when the DUT presents
// dout_valid or a quadrature change.
// ---------------------------------------------------------------------------
module tb_trackball_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       flip;

  logic       h_clk, h_dir, v_clk, v_dir, rd, rd_axis;
  logic [7:0] dout;
  logic       dout_valid;
  logic [1:0] quad_x, quad_y;

  logic       hc_clk, hc_dir, vc_clk, vc_dir, rdc, rdc_axis;
  logic [7:0] doutc;
  logic       doutc_valid;
  logic [1:0] quadc_x, quadc_y;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_main[$];
  logic [7:0] exp_clr[$];
  logic [1:0] exp_qx[$];
  logic [1:0] exp_qy[$];

  logic [1:0] phase_x = 2'd0;
  logic [1:0] phase_y = 2'd0;
  logic [1:0] seq[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  logic [1:0] prev_qx = 2'b00;
  logic [1:0] prev_qy = 2'b00;

  always #5 clk = ~clk;

  trackball_counter #(.COUNT_W(8), .CLEAR_ON_READ(0), .SNAPSHOT(1)) dut (
    .clk(clk), .reset(reset),
    .h_clk(h_clk), .h_dir(h_dir), .v_clk(v_clk), .v_dir(v_dir),
    .flip(flip), .rd(rd), .rd_axis(rd_axis),
    .dout(dout), .dout_valid(dout_valid),
    .quad_x(quad_x), .quad_y(quad_y)
  );

  trackball_counter #(.COUNT_W(8), .CLEAR_ON_READ(1), .SNAPSHOT(1)) dut_c (
    .clk(clk), .reset(reset),
    .h_clk(hc_clk), .h_dir(hc_dir), .v_clk(vc_clk), .v_dir(vc_dir),
    .flip(flip), .rd(rdc), .rd_axis(rdc_axis),
    .dout(doutc), .dout_valid(doutc_valid),
    .quad_x(quadc_x), .quad_y(quadc_y)
  );

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic failNote(input string name);
    n_vec++;
    n_miss++;
    $display("[TB] FAIL %s: got unexpected event, expected none", name);
  endtask

  // Read-data monitors.
  always @(negedge clk) begin
    if (!reset && dout_valid) begin
      if (exp_main.size() == 0) failNote("dout_valid main");
      else checkOutput("dout main", dout, exp_main.pop_front());
    end
    if (!reset && doutc_valid) begin
      if (exp_clr.size() == 0) failNote("dout_valid clr");
      else checkOutput("dout clr", doutc, exp_clr.pop_front());
    end
  end

  // Quadrature monitors on the main instance.
  always @(negedge clk) begin
    if (quad_x !== prev_qx) begin
      if (exp_qx.size() == 0) failNote("quad_x change");
      else checkOutput("quad_x", {6'd0, quad_x}, {6'd0, exp_qx.pop_front()});
      prev_qx = quad_x;
    end
    if (quad_y !== prev_qy) begin
      if (exp_qy.size() == 0) failNote("quad_y change");
      else checkOutput("quad_y", {6'd0, quad_y}, {6'd0, exp_qy.pop_front()});
      prev_qy = quad_y;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggleH(input logic dir);
    h_dir = dir;
    h_clk = ~h_clk;
    if (dir ^ flip) phase_x = phase_x - 2'd1;
    else            phase_x = phase_x + 2'd1;
    exp_qx.push_back(seq[phase_x]);
    tick(8);
  endtask

  task automatic toggleV(input logic dir);
    v_dir = dir;
    v_clk = ~v_clk;
    if (dir ^ flip) phase_y = phase_y - 2'd1;
    else            phase_y = phase_y + 2'd1;
    exp_qy.push_back(seq[phase_y]);
    tick(8);
  endtask

  task automatic readMain(input logic axis, input logic [7:0] exp);
    rd = 1'b1;
    rd_axis = axis;
    exp_main.push_back(exp);
    tick(1);
    rd = 1'b0;
    tick(2);
  endtask

  task automatic toggleHc(input logic dir);
    hc_dir = dir;
    hc_clk = ~hc_clk;
    tick(8);
  endtask

  task automatic toggleVc(input logic dir);
    vc_dir = dir;
    vc_clk = ~vc_clk;
    tick(8);
  endtask

  task automatic readClr(input logic axis, input logic [7:0] exp);
    rdc = 1'b1;
    rdc_axis = axis;
    exp_clr.push_back(exp);
    tick(1);
    rdc = 1'b0;
    tick(2);
  endtask

  task automatic applyStimulus();
    // Reset state.
    #1;
    checkOutput("reset dout", dout, 8'h00);
    checkOutput("reset dout_valid", {7'd0, dout_valid}, 8'h00);
    checkOutput("reset quad_x", {6'd0, quad_x}, 8'h00);
    checkOutput("reset quad_y", {6'd0, quad_y}, 8'h00);
    tick(3);
    reset = 1'b0;
    tick(5);

    // Five up-steps on X.
    for (int i = 0; i < 5; i++) toggleH(1'b0);
    readMain(1'b0, 8'h05);

    // Back to zero, then wrap below zero and back above it.
    for (int i = 0; i < 5; i++) toggleH(1'b1);
    toggleH(1'b1);
    readMain(1'b0, 8'hFF);
    toggleH(1'b0);
    toggleH(1'b0);
    readMain(1'b0, 8'h01);

    // Cocktail flip: up-direction toggles count down on Y.
    flip = 1'b1;
    for (int i = 0; i < 3; i++) toggleV(1'b0);
    flip = 1'b0;
    readMain(1'b1, 8'h00);
    readMain(1'b0, 8'h01);
    readMain(1'b1, 8'hFD);

    // Snapshot: Y = 0x10 latched by the X read, then Y moves on.
    for (int i = 0; i < 19; i++) toggleV(1'b0);
    readMain(1'b0, 8'h01);
    for (int i = 0; i < 4; i++) toggleV(1'b0);
    readMain(1'b1, 8'h10);
    readMain(1'b0, 8'h01);
    readMain(1'b1, 8'h14);

    // Back-to-back strobes each produce their own pulse.
    rd = 1'b1;
    rd_axis = 1'b0;
    exp_main.push_back(8'h01);
    tick(1);
    rd_axis = 1'b1;
    exp_main.push_back(8'h14);
    tick(1);
    rd = 1'b0;
    tick(3);

    // Asynchronous reset mid-step with X = 0x33.
    for (int i = 0; i < 50; i++) toggleH(1'b0);
    readMain(1'b0, 8'h33);
    h_dir = 1'b0;
    h_clk = ~h_clk;
    @(posedge clk);
    #3;
    if (seq[phase_x] != 2'b00) exp_qx.push_back(2'b00);
    if (seq[phase_y] != 2'b00) exp_qy.push_back(2'b00);
    phase_x = 2'd0;
    phase_y = 2'd0;
    reset = 1'b1;
    #1;
    checkOutput("async reset dout", dout, 8'h00);
    checkOutput("async reset dout_valid", {7'd0, dout_valid}, 8'h00);
    checkOutput("async reset quad_x", {6'd0, quad_x}, 8'h00);
    checkOutput("async reset quad_y", {6'd0, quad_y}, 8'h00);
    tick(3);
    reset = 1'b0;
    tick(10);
    toggleH(1'b0);
    readMain(1'b0, 8'h01);
    readMain(1'b1, 8'h00);

    // Clear-on-read instance: a read coincident with an up-step.
    for (int i = 0; i < 7; i++) toggleHc(1'b0);
    hc_dir = 1'b0;
    hc_clk = ~hc_clk;
    repeat (3) @(posedge clk);
    #1;
    rdc = 1'b1;
    rdc_axis = 1'b0;
    exp_clr.push_back(8'h07);
    tick(1);
    rdc = 1'b0;
    tick(8);
    readClr(1'b0, 8'h01);
    readClr(1'b0, 8'h00);
    toggleVc(1'b0);
    toggleVc(1'b0);
    readClr(1'b0, 8'h00);
    readClr(1'b1, 8'h02);
    readClr(1'b0, 8'h00);
    readClr(1'b1, 8'h00);
    checkOutput("clr quad_x", {6'd0, quadc_x}, 8'h00);
    checkOutput("clr quad_y", {6'd0, quadc_y}, 8'h03);
  endtask

  initial begin
    reset    = 1'b1;
    flip     = 1'b0;
    h_clk    = 1'b0; h_dir  = 1'b0; v_clk  = 1'b0; v_dir  = 1'b0;
    rd       = 1'b0; rd_axis = 1'b0;
    hc_clk   = 1'b0; hc_dir = 1'b0; vc_clk = 1'b0; vc_dir = 1'b0;
    rdc      = 1'b0; rdc_axis = 1'b0;

    applyStimulus();

    // Drain with a bounded wait; anything left is a missed response.
    for (int i = 0; i < 20; i++) begin
      if (exp_main.size() == 0 && exp_clr.size() == 0 &&
          exp_qx.size() == 0 && exp_qy.size() == 0) break;
      @(posedge clk);
    end
    if (exp_main.size() != 0) begin
      n_vec++; n_miss++;
      $display("[TB] FAIL drain main: got no response, expected %0d more", exp_main.size());
    end
    if (exp_clr.size() != 0) begin
      n_vec++; n_miss++;
      $display("[TB] FAIL drain clr: got no response, expected %0d more", exp_clr.size());
    end
    if (exp_qx.size() != 0) begin
      n_vec++; n_miss++;
      $display("[TB] FAIL drain quad_x: got no change, expected %0d more", exp_qx.size());
    end
    if (exp_qy.size() != 0) begin
      n_vec++; n_miss++;
      $display("[TB] FAIL drain quad_y: got no change, expected %0d more", exp_qy.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/trackball_counter.md
Name: trackball_counter

Overview:
- Downstream consumer of the trackball emulator's h_clk/h_dir and v_clk/v_dir outputs.
- Converts each toggle of h_clk or v_clk into a signed step on an up/down position counter per axis.
- Presents the counters to the game CPU through a registered read port.
- Also drives 2-bit Gray-code quadrature outputs per axis, for cores whose original hardware decodes quadrature phases.

Parameters:
- COUNT_W, 8: width of each axis position counter and of dout.
- CLEAR_ON_READ, 0: 1 = the axis counter being read is zeroed in the same cycle it is sampled.
- SNAPSHOT, 1: 1 = a read of X also latches Y into a shadow register; a later Y read returns the shadow value.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- h_clk  in  1  horizontal step toggle from the trackball emulator; asynchronous to clk.
- h_dir  in  1  horizontal direction: 0 = increment, 1 = decrement.
- v_clk  in  1  vertical step toggle; asynchronous to clk.
- v_dir  in  1  vertical direction: 0 = increment, 1 = decrement.
- flip  in  1  1 = invert the direction of both axes (cocktail flip).
- rd  in  1  one-cycle read strobe, synchronous to clk.
- rd_axis  in  1  0 = X, 1 = Y; sampled when rd = 1.
- dout  out  COUNT_W  registered read data.
- dout_valid  out  1  one-cycle pulse, the cycle after rd.
- quad_x  out  2  X quadrature phases {B,A}.
- quad_y  out  2  Y quadrature phases {B,A}.

Behaviour:
- Reset (asynchronous, active-high):
  - Counters, shadow, dout and quad_x/quad_y clear to 0; dout_valid clears to 0.
  - Synchroniser and edge-detect flops clear to 0.
  - Reset mid-step discards the step in progress; no count occurs on the release edge.
- Input synchronisation:
  - h_clk, h_dir, v_clk, v_dir each pass through 2-FF synchronisers.
  - A third flop on each synced clk supports edge detection.
- Step detection:
  - step_h = synced h_clk XOR its delayed copy; both edges count, since the emulator toggles once per step. step_v likewise.
- Effective direction: dir_eff = synced_dir XOR flip.
  - dir_eff = 0: counter + 1.
  - dir_eff = 1: counter - 1.
- Counter arithmetic:
  - Modulo 2^COUNT_W; 0xFF + 1 = 0x00 and 0x00 - 1 = 0xFF.
  - No saturation.
- Latency: an h_clk toggle arriving before clk edge n is visible in the X counter after edge n+3.
- Quadrature sequence (one step per detected step):
  - Up sequence: 00 -> 01 -> 11 -> 10 -> 00.
  - Down sequence is the reverse.
  - Exactly one bit changes per step.
  - The quadrature state advances independently of reads and clears.
- Read port:
  - On rd, dout <= the selected value at the next edge, and dout_valid = 1 for that one cycle.
  - dout holds its value until the next rd.
  - The value returned is the counter value before any step in the same cycle.
- SNAPSHOT = 1:
  - rd with rd_axis = 0 latches the current Y counter into the shadow register.
  - rd with rd_axis = 1 returns the shadow.
- SNAPSHOT = 0: rd with rd_axis = 1 returns the live Y counter.
- CLEAR_ON_READ = 1:
  - The read axis counter is cleared when sampled.
  - A step in the same cycle is applied after the clear, leaving the counter at +1 or -1 (0x01 / 0xFF). It is never lost.
  - With SNAPSHOT = 1, an X read also clears the live Y counter, applying the same step rule.
- Simultaneous h and v steps are both applied in the same cycle; the axes are fully independent.
- rd asserted on consecutive cycles: each strobe is serviced and produces its own dout_valid pulse.
- Steps faster than 1 per 2 clk cycles are outside spec. The emulator's minimum half-period is 3000 clocks.

Test Plan:
- Reset, then 5 h_clk toggles with h_dir = 0, flip = 0, then rd with rd_axis = 0 -> dout = 0x05 with a one-cycle dout_valid; quad_x steps 00, 01, 11, 10, 00, 01.
- X counter at 0x00, one h_clk toggle with h_dir = 1 -> X = 0xFF; then 2 toggles with h_dir = 0 -> X = 0x01 (wrap in both directions).
- flip = 1, 3 v_clk toggles with v_dir = 0 -> Y = 0xFD; quad_y follows the down sequence 00, 10, 11, 01.
- SNAPSHOT = 1: Y = 0x10; rd X; then 4 v_clk toggles (dir 0); then rd Y -> dout = 0x10 (shadow), live Y = 0x14.
- CLEAR_ON_READ = 1: X = 0x07; rd X coincident with a detected up-step -> dout = 0x07, X afterwards = 0x01.
- Assert reset asynchronously mid-sequence with X = 0x33 -> dout, X, Y and quad_x/quad_y are 0 immediately, with no clk edge needed; after release, the first toggle gives X = 0x01.
